// File: rtl/morse_rx_decoder.sv
// Morse receive decoder: samples the Morse line once per half-second tick,
// turns ON/OFF run lengths into dots, dashes and character gaps, decodes
// each finished character to A=0..Z=25 (30 = invalid), and shifts the code
// into an 8-character, 5-bit-per-character display buffer.
module morse_rx_decoder #(
  parameter int DOT_LEN   = 1,
  parameter int DASH_LEN  = 3,
  parameter int CHAR_GAP  = 3,
  parameter int MAX_SYM   = 4,
  parameter int BUF_CHARS = 8
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iEnable,
  input  logic                   iClear,
  input  logic [3:0]             iHalfSec,
  input  logic                   iMorse,
  output logic [5*BUF_CHARS-1:0] oDisplayData,
  output logic [4:0]             oLastChar,
  output logic                   oCharValid,
  output logic [3:0]             oCharCount,
  output logic                   oBusy
);

  localparam int LEN_W = $clog2(MAX_SYM + 1);
  localparam int IDX_W = $clog2(MAX_SYM);
  localparam logic [4:0] CODE_EMPTY   = 5'd31;
  localparam logic [4:0] CODE_INVALID = 5'd30;
  localparam logic [2:0] RUN_MAX      = 3'd7;

  logic [3:0]         prev_half_sec;
  logic [2:0]         on_cnt, off_cnt;
  logic [MAX_SYM-1:0] sym_bits;
  logic [LEN_W-1:0]   sym_len;
  logic               err;

  logic               tick;
  logic [2:0]         nxt_on, nxt_off;
  logic [MAX_SYM-1:0] nxt_bits;
  logic [LEN_W-1:0]   nxt_len;
  logic               nxt_err;
  logic               commit_now;
  logic [4:0]         commit_code;

  // Symbols are stored LSB-first (bit i = symbol i, dash = 1); unused upper
  // bits are always zero, so the length plus the zero-extended pattern keys
  // the table directly.
  function automatic logic [4:0] lookup(input logic [2:0] len, input logic [3:0] bits);
    logic [4:0] code;
    code = CODE_INVALID;
    case ({len, bits})
      {3'd2, 4'b0010}: code = 5'd0;   // A .-
      {3'd4, 4'b0001}: code = 5'd1;   // B -...
      {3'd4, 4'b0101}: code = 5'd2;   // C -.-.
      {3'd3, 4'b0001}: code = 5'd3;   // D -..
      {3'd1, 4'b0000}: code = 5'd4;   // E .
      {3'd4, 4'b0100}: code = 5'd5;   // F ..-.
      {3'd3, 4'b0011}: code = 5'd6;   // G --.
      {3'd4, 4'b0000}: code = 5'd7;   // H ....
      {3'd2, 4'b0000}: code = 5'd8;   // I ..
      {3'd4, 4'b1110}: code = 5'd9;   // J .---
      {3'd3, 4'b0101}: code = 5'd10;  // K -.-
      {3'd4, 4'b0010}: code = 5'd11;  // L .-..
      {3'd2, 4'b0011}: code = 5'd12;  // M --
      {3'd2, 4'b0001}: code = 5'd13;  // N -.
      {3'd3, 4'b0111}: code = 5'd14;  // O ---
      {3'd4, 4'b0110}: code = 5'd15;  // P .--.
      {3'd4, 4'b1011}: code = 5'd16;  // Q --.-
      {3'd3, 4'b0010}: code = 5'd17;  // R .-.
      {3'd3, 4'b0000}: code = 5'd18;  // S ...
      {3'd1, 4'b0001}: code = 5'd19;  // T -
      {3'd3, 4'b0100}: code = 5'd20;  // U ..-
      {3'd4, 4'b1000}: code = 5'd21;  // V ...-
      {3'd3, 4'b0110}: code = 5'd22;  // W .--
      {3'd4, 4'b1001}: code = 5'd23;  // X -..-
      {3'd4, 4'b1101}: code = 5'd24;  // Y -.--
      {3'd4, 4'b0011}: code = 5'd25;  // Z --..
      default:         code = CODE_INVALID;
    endcase
    return code;
  endfunction

  assign tick  = (iHalfSec != prev_half_sec);
  assign oBusy = (sym_len != '0) | (on_cnt != '0) | err;

  // Next run/symbol state for the case where this clock carries a tick.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    nxt_on   = on_cnt;
    nxt_off  = off_cnt;
    nxt_bits = sym_bits;
    nxt_len  = sym_len;
    nxt_err  = err;
    if (iMorse) begin
      if (on_cnt != RUN_MAX) nxt_on = on_cnt + 3'd1;
      nxt_off = '0;
    end else if (on_cnt != '0) begin
      if (on_cnt != 3'(DOT_LEN) && on_cnt != 3'(DASH_LEN)) begin
        nxt_err = 1'b1;
      end else if (sym_len == LEN_W'(MAX_SYM)) begin
        nxt_err = 1'b1;  // too many symbols: the extra one is dropped
      end else begin
        nxt_bits[sym_len[IDX_W-1:0]] = (on_cnt == 3'(DASH_LEN));
        nxt_len = sym_len + LEN_W'(1);
      end
      nxt_on  = '0;
      nxt_off = 3'd1;
    end else if (off_cnt != RUN_MAX) begin
      nxt_off = off_cnt + 3'd1;
    end
  end

  // A character ends when the OFF run reaches the gap length with content pending.
  assign commit_now  = (nxt_off == 3'(CHAR_GAP)) && ((nxt_len != '0) || nxt_err);
  assign commit_code = nxt_err ? CODE_INVALID : lookup(3'(nxt_len), 4'(nxt_bits));

  // Tick edge detection, run tracking, character commit and buffer shifting.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      prev_half_sec <= '0;
      on_cnt        <= '0;
      off_cnt       <= '0;
      sym_bits      <= '0;
      sym_len       <= '0;
      err           <= 1'b0;
      // NOTE: the display buffer is a plain register vector with a defined reset value, not a RAM.
      oDisplayData  <= {BUF_CHARS{CODE_EMPTY}};
      oLastChar     <= CODE_EMPTY;
      oCharValid    <= 1'b0;
      oCharCount    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      prev_half_sec <= iHalfSec;
      oCharValid    <= 1'b0;
      if (iClear) begin
        on_cnt       <= '0;
        off_cnt      <= '0;
        sym_bits     <= '0;
        sym_len      <= '0;
        err          <= 1'b0;
        oDisplayData <= {BUF_CHARS{CODE_EMPTY}};
        oLastChar    <= CODE_EMPTY;
        oCharCount   <= '0;
      end else if (!iEnable) begin
        on_cnt   <= '0;
        off_cnt  <= '0;
        sym_bits <= '0;
        sym_len  <= '0;
        err      <= 1'b0;
      end else if (tick) begin
        on_cnt   <= nxt_on;
        off_cnt  <= nxt_off;
        sym_bits <= nxt_bits;
        sym_len  <= nxt_len;
        err      <= nxt_err;
        if (commit_now) begin
          sym_bits     <= '0;
          sym_len      <= '0;
          err          <= 1'b0;
          oDisplayData <= {oDisplayData[5*BUF_CHARS-6:0], commit_code};
          oLastChar    <= commit_code;
          oCharValid   <= 1'b1;
          if (oCharCount != 4'(BUF_CHARS)) oCharCount <= oCharCount + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder: directed scenarios plus randomized character
// streams, checked against a text-level Morse model (dot/dash strings).
module tb_morse_rx_decoder;

  logic        iCLK = 1'b0;
  logic        iRST, iEnable, iClear, iMorse;
  logic [3:0]  iHalfSec;
  logic [39:0] oDisplayData;
  logic [4:0]  oLastChar;
  logic        oCharValid;
  logic [3:0]  oCharCount;
  logic        oBusy;

  morse_rx_decoder dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iClear(iClear),
    .iHalfSec(iHalfSec), .iMorse(iMorse), .oDisplayData(oDisplayData),
    .oLastChar(oLastChar), .oCharValid(oCharValid), .oCharCount(oCharCount),
    .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  string morse_tab [26];
  string unused_tab [4];
  int    bad_len [5];

  logic [4:0] hist[$];    // every code committed since last clear/reset
  logic [4:0] pend_q[$];  // codes expected since the last output check
  logic [4:0] obs_q[$];   // codes seen on oCharValid pulses

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every clock that oCharValid is high records one commit.
  always @(negedge iCLK) if (oCharValid === 1'b1) obs_q.push_back(oLastChar);

  function automatic logic [4:0] expect_code(input string pat);
    if (pat.len() > 4) return 5'd30;
    for (int i = 0; i < pat.len(); i++)
      if (pat[i] != "." && pat[i] != "-") return 5'd30;
    for (int k = 0; k < 26; k++)
      if (pat == morse_tab[k]) return 5'(k);
    return 5'd30;
  endfunction

  function automatic logic [39:0] exp_display();
    logic [39:0] d;
    d = {8{5'd31}};
    foreach (hist[i]) d = {d[34:0], hist[i]};
    return d;
  endfunction

  task automatic expect_char(input logic [4:0] code);
    hist.push_back(code);
    pend_q.push_back(code);
  endtask

  task automatic send_tick(input logic m);
    @(posedge iCLK);
    #1;
    iMorse   = m;
    iHalfSec = iHalfSec + 4'd1;
    repeat ($urandom_range(0, 2)) @(posedge iCLK);
  endtask

  task automatic send_stream(input string s);
    for (int i = 0; i < s.len(); i++) send_tick(s[i] == "1");
  endtask

  // '.' = 1-tick ON, '-' = 3-tick ON, digit = ON run of that many ticks.
  task automatic send_pattern(input string pat, input int gap);
    byte c;
    int  n;
    for (int i = 0; i < pat.len(); i++) begin
      c = pat[i];
      if (c == ".")      n = 1;
      else if (c == "-") n = 3;
      else               n = int'(c) - 48;
      repeat (n) send_tick(1'b1);
      if (i < pat.len() - 1) repeat ($urandom_range(1, 2)) send_tick(1'b0);
    end
    repeat (gap) send_tick(1'b0);
    expect_char(expect_code(pat));
  endtask

  task automatic settle();
    repeat (4) @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pulses"}, 40'(obs_q.size()), 40'(pend_q.size()));
    for (int i = 0; i < obs_q.size() && i < pend_q.size(); i++)
      check({tag, "_code"}, obs_q[i], pend_q[i]);
    check({tag, "_disp"}, oDisplayData, exp_display());
    check({tag, "_cnt"}, oCharCount, (hist.size() > 8) ? 8 : hist.size());
    check({tag, "_last"}, oLastChar, (hist.size() == 0) ? 5'd31 : hist[$]);
    check({tag, "_busy"}, oBusy, 1'b0);
    obs_q.delete();
    pend_q.delete();
  endtask

  task automatic do_clear();
    @(posedge iCLK);
    #1 iClear = 1'b1;
    @(posedge iCLK);
    #1 iClear = 1'b0;
    hist.delete();
    obs_q.delete();
    pend_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_disp"}, oDisplayData, {8{5'd31}});
    check({tag, "_last"}, oLastChar, 5'd31);
    check({tag, "_valid"}, oCharValid, 1'b0);
    check({tag, "_cnt"}, oCharCount, 4'd0);
    check({tag, "_busy"}, oBusy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    string pat;
    string sym;
    int    r, n, pos;

    morse_tab = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                  ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                  "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    unused_tab = '{"..--", ".-.-", "---.", "----"};
    bad_len    = '{2, 4, 5, 6, 9};

    iRST = 1'b1; iEnable = 1'b1; iClear = 1'b0; iMorse = 1'b0; iHalfSec = 4'd0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_reset_values("reset");
    @(posedge iCLK);
    #1 iRST = 1'b0;

    // Single letter A
    send_stream("10111000");
    expect_char(5'd0);
    settle();
    check_outputs("A");

    // SOS
    send_stream("10101000");
    send_stream("11101110111000");
    send_stream("10101000");
    expect_char(5'd18); expect_char(5'd14); expect_char(5'd18);
    settle();
    check("sos_low15", oDisplayData[14:0], {5'd18, 5'd14, 5'd18});
    check_outputs("SOS");

    // Invalid: 2-tick ON run, then five dots
    send_stream("11000");
    expect_char(5'd30);
    send_stream("101010101000");
    expect_char(5'd30);
    settle();
    check_outputs("INV");

    // Nine letters A..I: buffer keeps B..I, count saturates
    do_clear();
    for (int k = 0; k < 9; k++) send_pattern(morse_tab[k], $urandom_range(3, 5));
    settle();
    check("nine_newest", oDisplayData[4:0], 5'd8);
    check_outputs("NINE");

    // Enable dropped mid-character discards the partial character
    send_stream("101");
    settle();
    check("en_busy_before", oBusy, 1'b1);
    @(posedge iCLK);
    #1 iEnable = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    check("en_busy_off", oBusy, 1'b0);
    send_stream("111");
    settle();
    check("en_busy_held", oBusy, 1'b0);
    @(posedge iCLK);
    #1 iEnable = 1'b1;
    send_stream("000");
    settle();
    check_outputs("EN");

    // Clear coincides with the commit edge of an A
    send_stream("1011100");
    @(posedge iCLK);
    #1;
    iMorse   = 1'b0;
    iHalfSec = iHalfSec + 4'd1;
    iClear   = 1'b1;
    @(posedge iCLK);
    #1 iClear = 1'b0;
    hist.delete();
    settle();
    check_outputs("CLR");

    // Asynchronous reset in the middle of a dash
    send_tick(1'b1);
    send_tick(1'b1);
    settle();
    check("rst_busy_before", oBusy, 1'b1);
    #1 iRST = 1'b1;
    iMorse = 1'b0;
    @(negedge iCLK);
    check_reset_values("midrst");
    @(posedge iCLK);
    #1 iRST = 1'b0;
    hist.delete();
    obs_q.delete();
    pend_q.delete();

    // Randomized character stream
    for (int c = 0; c < 40; c++) begin
      r = $urandom_range(0, 9);
      pat = "";
      if (r <= 6) begin
        pat = morse_tab[$urandom_range(0, 25)];
      end else if (r == 7) begin
        n   = $urandom_range(1, 3);
        pos = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++) begin
          if (i == pos) sym = $sformatf("%0d", bad_len[$urandom_range(0, 4)]);
          else if ($urandom_range(0, 1) == 1) sym = "-";
          else sym = ".";
          pat = {pat, sym};
        end
      end else if (r == 8) begin
        n = $urandom_range(5, 6);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 1) == 1) sym = "-";
          else sym = ".";
          pat = {pat, sym};
        end
      end else begin
        pat = unused_tab[$urandom_range(0, 3)];
      end
      send_pattern(pat, ($urandom_range(0, 4) == 0) ? $urandom_range(8, 12) : $urandom_range(3, 6));
      if (c % 8 == 7) begin
        settle();
        check_outputs($sformatf("RND%0d", c));
      end
    end
    settle();
    check_outputs("RNDEND");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
